// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM.
// Sequences one shared ALU and one unified memory through FETCH/DECODE/EXECUTE
// steps, stalls on the memory ready handshake and aborts a memory access that
// waits too long. Selects are decoded from the current state; write enables
// additionally qualify on MemReady/Zero in the same cycle and are gated off
// while reset_n is low.
module multicycle_controller #(
   parameter int BUS_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       IllegalOp,
   output logic       BusErr,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
   localparam logic [TO_W-1:0] CNT_LIM = TO_W'(BUS_TIMEOUT);

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   logic       timeout_s;
   logic       hold_s;
   logic       req_s, pcw_s, adr_s, mw_s, irw_s, rw_s, ill_s, berr_s;
   logic [1:0] rsrc_s, asrc_s, bsrc_s, imm_s;
   logic [2:0] alu_s;

   // ALU operation from funct3; subtraction only when the caller allows it (R-type)
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
      logic [2:0] res;
      case (f3)
         3'b000:  res = sub_sel ? 3'b001 : 3'b000;
         3'b010:  res = 3'b101;
         3'b110:  res = 3'b011;
         3'b111:  res = 3'b010;
         default: res = 3'b000;
      endcase
      return res;
   endfunction

   // A memory wait expires when the count has reached the limit and the memory is still busy
   always_comb begin
      if (BUS_TIMEOUT != 0) begin
         timeout_s = (cnt_q == CNT_LIM) && !MemReady;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Next-state and per-state control decode
   always_comb begin
      state_d = state_q;
      hold_s  = 1'b0;
      req_s   = 1'b0;
      pcw_s   = 1'b0;
      adr_s   = 1'b0;
      mw_s    = 1'b0;
      irw_s   = 1'b0;
      rw_s    = 1'b0;
      ill_s   = 1'b0;
      berr_s  = 1'b0;
      rsrc_s  = 2'b00;
      asrc_s  = 2'b00;
      bsrc_s  = 2'b00;
      imm_s   = 2'b00;
      alu_s   = 3'b000;
      case (state_q)
         S_FETCH: begin
            req_s  = 1'b1;
            bsrc_s = 2'b10;
            rsrc_s = 2'b10;
            if (MemReady) begin
               irw_s   = 1'b1;
               pcw_s   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_s) begin
               berr_s  = 1'b1;
               state_d = S_FETCH;
            end else begin
               hold_s  = 1'b1;
            end
         end
         S_DECODE: begin
            asrc_s = 2'b01;
            bsrc_s = 2'b01;
            imm_s  = 2'b10;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  ill_s   = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            asrc_s = 2'b10;
            bsrc_s = 2'b01;
            if (op == OP_SW) begin
               imm_s   = 2'b01;
               state_d = S_MEMWRITE;
            end else begin
               imm_s   = 2'b00;
               state_d = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            req_s = 1'b1;
            adr_s = 1'b1;
            if (MemReady) begin
               state_d = S_MEMWB;
            end else if (timeout_s) begin
               berr_s  = 1'b1;
               state_d = S_FETCH;
            end else begin
               hold_s  = 1'b1;
            end
         end
         S_MEMWB: begin
            rsrc_s  = 2'b01;
            rw_s    = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            req_s = 1'b1;
            adr_s = 1'b1;
            if (MemReady) begin
               mw_s    = 1'b1;
               state_d = S_FETCH;
            end else if (timeout_s) begin
               berr_s  = 1'b1;
               state_d = S_FETCH;
            end else begin
               hold_s  = 1'b1;
            end
         end
         S_EXECUTER: begin
            asrc_s  = 2'b10;
            bsrc_s  = 2'b00;
            alu_s   = alu_decode(funct3, funct7b5);
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            asrc_s  = 2'b10;
            bsrc_s  = 2'b01;
            alu_s   = alu_decode(funct3, 1'b0);
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rw_s    = 1'b1;
            state_d = S_FETCH;
         end
         S_BEQ: begin
            asrc_s  = 2'b10;
            alu_s   = 3'b001;
            imm_s   = 2'b10;
            pcw_s   = Zero;
            state_d = S_FETCH;
         end
         S_JAL: begin
            asrc_s  = 2'b01;
            bsrc_s  = 2'b10;
            imm_s   = 2'b11;
            pcw_s   = 1'b1;
            state_d = S_ALUWB;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Wait counter: counts only while stalled in a memory state, otherwise restarts at zero
   always_comb begin
      if (hold_s) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = {TO_W{1'b0}};
      end
   end

   // State and wait-counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         cnt_q   <= {TO_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Enables are suppressed while reset is held so nothing writes during reset
   assign MemReq     = req_s  & reset_n;
   assign PCWrite    = pcw_s  & reset_n;
   assign MemWrite   = mw_s   & reset_n;
   assign IRWrite    = irw_s  & reset_n;
   assign RegWrite   = rw_s   & reset_n;
   assign IllegalOp  = ill_s  & reset_n;
   assign BusErr     = berr_s & reset_n;
   assign AdrSrc     = adr_s;
   assign ResultSrc  = rsrc_s;
   assign ALUSrcA    = asrc_s;
   assign ALUSrcB    = bsrc_s;
   assign ALUControl = alu_s;
   assign ImmSrc     = imm_s;
   assign State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios with literal
// expectations, then randomized instruction streams compared every cycle
// against a route-table model of the instruction sequencing.
module tb_multicycle_controller;

   localparam int BT = 15;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, MemReady;
   logic       MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp, BusErr;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;

   // model: current state number, cycles waited in a memory state, remaining route
   int m_state = 0;
   int m_wait  = 0;
   int plan[$];

   multicycle_controller #(.BUS_TIMEOUT(BT), .TO_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .IllegalOp(IllegalOp), .BusErr(BusErr), .State(State)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic rtype);
      if (f3 == 3'b000 && f7 && rtype) return 3'b001;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      return 3'b000;
   endfunction

   // expected packed outputs for one cycle, straight from the per-state rules
   function automatic logic [22:0] model_out(input int st, input int wt, input logic rst_act,
                                             input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7, input logic z, input logic rdy);
      logic req, pcw, adr, mw, irw, rw, ill, be, tmo;
      logic [1:0] rs, a, b, imm;
      logic [2:0] alu;
      int s;
      s = rst_act ? 0 : st;
      tmo = (BT != 0) && (wt == BT) && !rdy;
      {req, pcw, adr, mw, irw, rw, ill, be} = 8'h00;
      rs = 2'b00; a = 2'b00; b = 2'b00; imm = 2'b00; alu = 3'b000;
      case (s)
         0: begin req = 1'b1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; be = tmo; end
         1: begin a = 2'b01; b = 2'b01; imm = 2'b10;
                  ill = !(o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL); end
         2: begin a = 2'b10; b = 2'b01; imm = (o == SW) ? 2'b01 : 2'b00; end
         3: begin req = 1'b1; adr = 1'b1; be = tmo; end
         4: begin rs = 2'b01; rw = 1'b1; end
         5: begin req = 1'b1; adr = 1'b1; mw = rdy; be = tmo; end
         6: begin a = 2'b10; alu = alu_of(f3, f7, 1'b1); end
         7: begin a = 2'b10; b = 2'b01; alu = alu_of(f3, f7, 1'b0); end
         8: begin rw = 1'b1; end
         9: begin a = 2'b10; alu = 3'b001; imm = 2'b10; pcw = z; end
         10: begin a = 2'b01; b = 2'b10; imm = 2'b11; pcw = 1'b1; end
         default: begin end
      endcase
      if (rst_act) {req, pcw, mw, irw, rw, ill, be} = 7'h00;
      return {req, pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ill, be, s[3:0]};
   endfunction

   // per-cycle compare at the falling edge, then advance the model to the next cycle
   always @(negedge clk) begin
      logic [22:0] exp_v, got_v;
      logic tmo;
      exp_v = model_out(m_state, m_wait, !reset_n, op, funct3, funct7b5, Zero, MemReady);
      got_v = {MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, IllegalOp, BusErr, State};
      chk("cycle outputs", {9'd0, got_v}, {9'd0, exp_v});
      tmo = (BT != 0) && (m_wait == BT) && !MemReady;
      if (!reset_n) begin
         m_state = 0; m_wait = 0; plan.delete();
      end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
         if (MemReady) begin
            if (m_state == 0) m_state = 1;
            else m_state = (plan.size() > 0) ? plan.pop_front() : 0;
            m_wait = 0;
         end else if (tmo) begin
            m_state = 0; m_wait = 0; plan.delete();
         end else begin
            m_wait++;
         end
      end else begin
         if (m_state == 1) begin
            plan.delete();
            case (op)
               LW: plan = '{2, 3, 4, 0};
               SW: plan = '{2, 5, 0};
               RT: plan = '{6, 8, 0};
               IT: plan = '{7, 8, 0};
               BQ: plan = '{9, 0};
               JL: plan = '{10, 8, 0};
               default: plan = '{0};
            endcase
         end
         m_state = (plan.size() > 0) ? plan.pop_front() : 0;
         m_wait = 0;
      end
   end

   initial begin
      int mode;
      reset_n = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      chk("reset State", State, 4'd0);
      chk("reset enables", {MemReq, PCWrite, MemWrite, IRWrite, RegWrite, IllegalOp, BusErr}, 7'h00);
      chk("reset ALUSrcB", ALUSrcB, 2'b10);
      chk("reset ResultSrc", ResultSrc, 2'b10);
      repeat (2) nxt();
      reset_n = 1'b1;

      // lw with MemReady high: 0,1,2,3,4 then back to FETCH
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("lw State", State, (k == 0) ? 4'd0 : 4'(k));
         chk("lw RegWrite", RegWrite, (k == 4) ? 1'b1 : 1'b0);
         if (k == 2) chk("lw ImmSrc", ImmSrc, 2'b00);
         nxt();
      end

      // sw with three stalled MEMWRITE cycles
      op = SW;
      #2 chk("sw start State", State, 4'd0);
      nxt(); nxt();
      MemReady = 1'b0;
      #2 chk("sw ImmSrc", ImmSrc, 2'b01);
      nxt();
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("sw wait State", State, 4'd5);
         chk("sw wait MemWrite", MemWrite, 1'b0);
         nxt();
      end
      MemReady = 1'b1;
      #2;
      chk("sw MemWrite", MemWrite, 1'b1);
      chk("sw last State", State, 4'd5);
      nxt();

      // R-type sub, then I-type with the same funct fields
      op = RT; funct3 = 3'b000; funct7b5 = 1'b1;
      #2 chk("R start State", State, 4'd0);
      nxt(); nxt();
      #2 chk("R State", State, 4'd6);
      chk("R ALUControl", ALUControl, 3'b001);
      nxt(); nxt();
      op = IT;
      #2 chk("I start State", State, 4'd0);
      nxt(); nxt();
      #2 chk("I State", State, 4'd7);
      chk("I ALUControl", ALUControl, 3'b000);
      nxt(); nxt();

      // beq taken / not taken
      op = BQ; Zero = 1'b1;
      nxt(); nxt();
      #2 chk("beq State", State, 4'd9);
      chk("beq taken PCWrite", PCWrite, 1'b1);
      chk("beq ImmSrc", ImmSrc, 2'b10);
      nxt();
      Zero = 1'b0;
      nxt(); nxt();
      #2 chk("beq not-taken PCWrite", PCWrite, 1'b0);
      nxt();

      // jal then ALUWB write of the link value
      op = JL;
      nxt(); nxt();
      #2 chk("jal ImmSrc", ImmSrc, 2'b11);
      chk("jal PCWrite", PCWrite, 1'b1);
      nxt();
      #2 chk("jal ALUWB State", State, 4'd8);
      chk("jal RegWrite", RegWrite, 1'b1);
      nxt();

      // unsupported opcode
      op = BAD;
      #2 chk("ill start State", State, 4'd0);
      nxt();
      #2 chk("IllegalOp pulse", IllegalOp, 1'b1);
      chk("ill enables", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'h0);
      nxt();
      #2 chk("ill back to FETCH", State, 4'd0);
      chk("IllegalOp cleared", IllegalOp, 1'b0);

      // FETCH timeout: BusErr on the 16th stalled cycle
      MemReady = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         if (t > 1) #2;
         if (t == 15) chk("no BusErr at 15", BusErr, 1'b0);
         if (t == 16) begin
            chk("BusErr at 16", BusErr, 1'b1);
            chk("timeout IR/PC write", {IRWrite, PCWrite}, 2'b00);
         end
         nxt();
      end
      #2 chk("BusErr single pulse", BusErr, 1'b0);

      // reset in the middle of MEMREAD
      op = LW; MemReady = 1'b1;
      nxt(); nxt();
      MemReady = 1'b0;
      nxt();
      #2 chk("MEMREAD State", State, 4'd3);
      nxt();
      #2 reset_n = 1'b0;
      #1;
      chk("abort State", State, 4'd0);
      chk("abort enables", {MemReq, PCWrite, MemWrite, IRWrite, RegWrite, BusErr}, 6'h00);
      nxt();
      reset_n = 1'b1; MemReady = 1'b1;

      // randomized instruction streams with varying memory responsiveness
      for (int c = 0; c < 4000; c++) begin
         mode = (c / 500) % 4;
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
         if (m_state == 0) begin
            case ($urandom_range(0, 7))
               0: op = LW;
               1: op = SW;
               2: op = RT;
               3: op = IT;
               4: op = BQ;
               5: op = JL;
               6: op = 7'($urandom);
               default: op = BAD;
            endcase
            funct3   = 3'($urandom);
            funct7b5 = 1'($urandom);
         end
         Zero = 1'($urandom);
         case (mode)
            0: MemReady = 1'b1;
            1: MemReady = 1'($urandom);
            2: MemReady = ($urandom_range(0, 19) == 0);
            default: MemReady = ($urandom_range(0, 3) != 0);
         endcase
         nxt();
      end

      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
